// File: rtl/irda_parity_transmitter.sv
// irda_parity_transmitter
//
// Transmit end of the 11-bit parity-framed IrDA link. A 7-bit word is
// accepted over a Send/Ready handshake. It is wrapped as
// {stop1, stop0, parity, data[6:0], start} and shifted out LSB first,
// one bit every CLKS_PER_BIT clocks. Each 0 bit is sent as a PULSE_CLKS-wide
// pulse at the start of its bit period. Each 1 bit is sent as no pulse, so
// the idle line (TxOut=0) is a continuous mark.
//
// Optional build macro: IRDA_TX_PARITY_INJECT_EN
//   When it is defined, the InjectParityError input is added. It is sampled
//   at accept together with InData, and it inverts the parity bit of that
//   one frame.
//
// Ports:
//   Clock             in   system clock, rising edge
//   Reset             in   asynchronous active-high reset
//   InData[6:0]       in   payload word, registered at accept
//   Send              in   valid: request to transmit InData
//   InjectParityError in   (macro builds only) corrupt parity of this frame
//   Ready             out  high while idle and able to accept
//   TxOut             out  registered IrDA-encoded serial output, 1 = LED pulse
//   Done              out  one-cycle strobe in the cycle after the last bit
module irda_parity_transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PULSE_CLKS   = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [6:0] InData,
  input  logic       Send,
`ifdef IRDA_TX_PARITY_INJECT_EN
  input  logic       InjectParityError,
`endif
  output logic       Ready,
  output logic       TxOut,
  output logic       Done
);

  localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CYC_W-1:0] LAST_CYC  = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [CYC_W-1:0] PULSE_END = CYC_W'(PULSE_CLKS);
  localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
  localparam logic [3:0]       LAST_BIT  = 4'd10;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [10:0]      frame_q, frame_d;
  logic [3:0]       bit_q, bit_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             inject;
  logic             accept;

`ifdef IRDA_TX_PARITY_INJECT_EN
  assign inject = InjectParityError;
`else
  assign inject = 1'b0;
`endif

  assign accept = Send && (state_q == IDLE);

  // Next-state logic. The bit and cycle counters always give the position of
  // the *next* cycle inside the frame. This lets tx_d look up the bit that
  // will be on the line next cycle, so TxOut can come straight from a flop.
  // It also means the start pulse appears in the first cycle after accept.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          // Even parity over data plus parity bit; inject flips it for test.
          frame_d = {2'b11, (^InData) ^ inject, InData, 1'b0};
          bit_d   = 4'd0;
          cyc_d   = '0;
        end
      end
      SEND: begin
        if (cyc_q == LAST_CYC) begin
          cyc_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = IDLE;
            bit_d   = 4'd0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A 0 bit is encoded as a pulse during the first PULSE_CLKS clocks.
    tx_d = (state_d == SEND) && !frame_d[bit_d] && (cyc_d < PULSE_END);
  end

  // State registers. Reset aborts any frame in flight and forces the line
  // to mark at once.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      tx_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign Ready = (state_q == IDLE);
  assign TxOut = tx_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_irda_parity_transmitter.sv
module tb_irda_parity_transmitter;

   localparam int CPB          = 16;
   localparam int PW           = 3;
   localparam int FRAME_CYCLES = 11 * CPB;
   localparam int PERIOD       = FRAME_CYCLES + 1;

   logic       Clock     = 1'b0;
   logic       Reset     = 1'b1;
   logic       Send      = 1'b0;
   logic       injectErr = 1'b0;
   logic [6:0] InData    = 7'd0;
   logic       Ready;
   logic       TxOut;
   logic       Done;

   int errorCount = 0;
   int checkCount = 0;

   // 100 MHz-style free-running clock
   always #5 Clock = ~Clock;

   irda_parity_transmitter #(
      .CLKS_PER_BIT(CPB),
      .PULSE_CLKS  (PW)
   ) dut (
      .Clock            (Clock),
      .Reset            (Reset),
      .InData           (InData),
      .Send             (Send),
`ifdef IRDA_TX_PARITY_INJECT_EN
      .InjectParityError(injectErr),
`endif
      .Ready            (Ready),
      .TxOut            (TxOut),
      .Done             (Done)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Expected line level in frame cycle k for a given 11-bit frame
   function automatic int expTx(input logic [10:0] frame, input int k);
      if (k >= FRAME_CYCLES) return 0;
      if (frame[k / CPB]) return 0;
      return ((k % CPB) < PW) ? 1 : 0;
   endfunction

   // Reference frame builder for the random loopback and streaming tests
   function automatic logic [10:0] buildFrame(input logic [6:0] w, input logic inj);
      return {2'b11, (^w) ^ inj, w, 1'b0};
   endfunction

   // Raise Send for one cycle; returns at the sampling point of frame cycle 0
   task automatic applyStimulus(input logic [6:0] word, input logic inj);
      @(negedge Clock);
      InData    = word;
      injectErr = inj;
      Send      = 1'b1;
      @(negedge Clock);
      Send      = 1'b0;
      injectErr = 1'b0;
   endtask

   // Send one word and compare every cycle of the frame against a hand-built
   // frame. Also scrambles InData and pokes Send mid-frame; neither may matter.
   task automatic runFrame(input string tag, input logic [6:0] word, input logic [10:0] expFrame);
      applyStimulus(word, 1'b0);
      for (int k = 0; k <= FRAME_CYCLES; k++) begin
         if (k > 0) @(negedge Clock);
         checkOutput({tag, "_tx"},    int'(TxOut), expTx(expFrame, k));
         checkOutput({tag, "_ready"}, int'(Ready), (k == FRAME_CYCLES) ? 1 : 0);
         checkOutput({tag, "_done"},  int'(Done),  (k == FRAME_CYCLES) ? 1 : 0);
         if (k == 20) InData = ~word;
         if (k == 60) Send = 1'b1;
         if (k == 61) Send = 1'b0;
      end
   endtask

   // Main sequence
   initial begin
      logic [6:0]  w;
      logic [10:0] ef;
      logic [10:0] rx;
      logic [10:0] pulseSeen;
      logic        inj;

      // Reset state
      repeat (3) @(negedge Clock);
      checkOutput("rst_ready", int'(Ready), 1);
      checkOutput("rst_tx",    int'(TxOut), 0);
      checkOutput("rst_done",  int'(Done),  0);
      Reset = 1'b0;
      repeat (2) @(negedge Clock);
      checkOutput("idle_ready", int'(Ready), 1);

      // Directed frames with hand-computed frame bits
      runFrame("w55", 7'h55, 11'b11010101010);
      runFrame("w7f", 7'h7F, 11'b11111111110);
      runFrame("w01", 7'h01, 11'b11100000010);

      // Send held high and InData changing every cycle: accepts 177 apart
      for (int n = 0; n <= 3 * PERIOD; n++) begin
         @(negedge Clock);
         if (n >= 1) begin
            int k;
            int fr;
            k  = (n - 1) % PERIOD;
            fr = (n - 1) / PERIOD;
            w  = 7'((fr * PERIOD * 37 + 5) & 127);
            ef = buildFrame(w, 1'b0);
            checkOutput("b2b_tx",    int'(TxOut), expTx(ef, k));
            checkOutput("b2b_done",  int'(Done),  (k == FRAME_CYCLES) ? 1 : 0);
            checkOutput("b2b_ready", int'(Ready), (k == FRAME_CYCLES) ? 1 : 0);
         end
         InData = 7'((n * 37 + 5) & 127);
         Send   = 1'b1;
      end
      Send = 1'b0;

      // Reset asserted at k=40 aborts the frame immediately
      applyStimulus(7'h00, 1'b0);
      repeat (40) @(negedge Clock);
      Reset = 1'b1;
      #1;
      checkOutput("abort_tx",    int'(TxOut), 0);
      checkOutput("abort_ready", int'(Ready), 1);
      checkOutput("abort_done",  int'(Done),  0);
      @(negedge Clock);
      Reset = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge Clock);
         checkOutput("post_abort_tx",    int'(TxOut), 0);
         checkOutput("post_abort_done",  int'(Done),  0);
         checkOutput("post_abort_ready", int'(Ready), 1);
      end
      runFrame("fresh55", 7'h55, 11'b11010101010);

      // Loopback: decode pulses back into frame bits for random words
      for (int i = 0; i < 200; i++) begin
         w = 7'($urandom_range(0, 127));
`ifdef IRDA_TX_PARITY_INJECT_EN
         inj = (i == 57) ? 1'b1 : 1'b0;
`else
         inj = 1'b0;
`endif
         pulseSeen = '0;
         applyStimulus(w, inj);
         for (int k = 0; k <= FRAME_CYCLES; k++) begin
            if (k > 0) @(negedge Clock);
            if (k < FRAME_CYCLES && TxOut) pulseSeen[k / CPB] = 1'b1;
         end
         rx = ~pulseSeen;
         checkOutput("lb_start",  int'(rx[0]),     0);
         checkOutput("lb_stops",  int'(rx[10:9]),  3);
         checkOutput("lb_parity", int'(^rx[8:1]),  int'(inj));
         checkOutput("lb_data",   int'(rx[7:1]),   int'(w));
         checkOutput("lb_done",   int'(Done),      1);
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/irda_parity_transmitter.md
Name: irda_parity_transmitter

Overview:
- Serial transmitter for the 11-bit parity-framed IrDA link. It is the transmit end of the link whose receive side checks parity and framing.
- Accepts a 7-bit word over a ready/valid handshake and builds the frame {stop1, stop0, parity, data[6:0], start}.
- Shifts the frame out bit 0 first, one bit per CLKS_PER_BIT clocks, with IrDA-style pulse encoding: a logic 0 is sent as a short pulse, a logic 1 as no pulse.
- Sits between the transmit-side controller and the IR LED driver.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per bit period. Legal range 4..1024.
- PULSE_CLKS, 3: width in clocks of the pulse that encodes a 0 bit. Legal range 1..CLKS_PER_BIT-1.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- InData  input  7  payload word; sampled on accept.
- Send  input  1  valid; a request to transmit InData.
- Ready  output  1  high when idle and able to accept.
- TxOut  output  1  IrDA-encoded serial output; 1 = LED pulse.
- Done  output  1  one-cycle strobe at the end of a frame.

Behaviour:
- Reset (async, active-high):
  - State IDLE; all counters 0.
  - Ready=1, TxOut=0, Done=0, immediately on assertion.
  - Reset during a frame aborts it; no partial frame resumes after reset release.
- Handshake:
  - Accept on a rising edge where Send=1 and Ready=1.
  - Send while Ready=0 is ignored; the request is not queued.
  - InData is registered at accept; later changes to InData have no effect on the frame in flight.
- Frame construction at accept:
  - bit0 = 0 (start).
  - bits1..7 = InData[0..6].
  - bit8 = XOR of InData[6:0] (even parity over data plus parity).
  - bits9..10 = 1 (two stop bits).
- FSM states:
  - IDLE: Ready=1. Transition to SEND on accept.
  - SEND: Ready=0. Bit counter runs 0..10; cycle counter runs 0..CLKS_PER_BIT-1.
    - On the last cycle of bit 10: assert Done for the following cycle and go to IDLE.
- Timing (number frame cycles k = 0 .. 11*CLKS_PER_BIT-1, starting with the cycle after the accept edge):
  - TxOut=1 in cycle k iff frame bit b = k / CLKS_PER_BIT is 0 and (k mod CLKS_PER_BIT) < PULSE_CLKS. Otherwise TxOut=0.
  - TxOut is driven directly from a flop (glitch-free); it is never combinational from inputs.
  - Done=1 in the single cycle k = 11*CLKS_PER_BIT. In that same cycle Ready=1 and TxOut=0.
- Back-to-back frames:
  - If Send is held high, the next accept happens on the edge ending the Done cycle.
  - This gives exactly 1 idle cycle between frames; total frame-to-frame period is 11*CLKS_PER_BIT+1 cycles.
- Counter widths: sized by $clog2 of the parameters. Wrap-around is not required beyond the legal ranges.
- Idle line: TxOut=0, which corresponds to a continuous mark.

Optional Feature:
- Macro: IRDA_TX_PARITY_INJECT_EN.
- Defined:
  - Adds input port InjectParityError (1 bit), sampled at accept together with InData.
  - When it is 1, bit8 is inverted for that frame only. Used to exercise receiver parity-error paths.
- Undefined:
  - The port is absent and parity is always correct.
  - Behaviour is otherwise identical in both builds.

Test Plan (CLKS_PER_BIT=16, PULSE_CLKS=3):
- Reset, then InData=7'b1010101 with a one-cycle Send.
  - Parity=0; pulses at bits 0,2,4,6,8, i.e. TxOut=1 for k=0-2, 32-34, 64-66, 96-98, 128-130.
  - Done at k=176; Ready=0 for cycles 0..175.
- InData=7'h7F.
  - Parity=1; a single pulse at k=0-2; no other TxOut activity through k=175; Done at k=176.
- InData=7'h01.
  - Parity=1; pulses at bits 0,2,3,4,5,6,7; bits 1,8,9,10 silent.
- Send held high with InData changing every cycle.
  - Each frame carries the value present at its accept edge.
  - Accepts occur exactly 177 cycles apart.
  - Send pulses while Ready=0 are ignored.
- Assert Reset at k=40 of a frame.
  - TxOut=0 and Ready=1 in the same cycle; no Done.
  - The next Send starts a fresh frame from the start bit.
- Loopback: decode TxOut (pulse => 0), sample mid-bit, and check 11-bit frames for 200 random words.
  - Start=0, stops=11, parity matches, and the data equals InData.
  - With IRDA_TX_PARITY_INJECT_EN and InjectParityError=1, exactly that frame shows a parity mismatch.
